pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: CPU2 instruction-fetch stage; owns the PC, fetches over imem req/ack, redirects on jump/branch.
// Optional overflow trap (HALT state, sticky pc_fault port) is enabled by defining PC_WRAP_TRAP_EN.
`ifndef PC_mem_Addr_n
`define PC_mem_Addr_n 16
`endif
`ifndef Instr_n
`define Instr_n 32
`endif

module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = `PC_mem_Addr_n,
    parameter int unsigned       INSTR_W  = `Instr_n,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_off,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
`ifdef PC_WRAP_TRAP_EN
    ,
    output logic               pc_fault
`endif
);

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
`ifdef PC_WRAP_TRAP_EN
    localparam logic [1:0] ST_HALT  = 2'd3;
`endif
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               redir_pend_q, redir_pend_d;
    logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    logic               redirect;
    logic [ADDR_W-1:0]  seq_pc, br_pc, target;

    assign redirect = jump | branch_taken;

`ifdef PC_WRAP_TRAP_EN
    logic              fault_q, fault_d;
    logic [ADDR_W+1:0] br_full;
    logic [ADDR_W:0]   seq_full;
    logic              br_ovf, seq_ovf;

    // Two guard bits: 00 means the signed branch result stayed inside the unsigned PC range.
    assign br_full  = {2'b00, pc_q} + {{2{branch_off[ADDR_W-1]}}, branch_off};
    assign seq_full = {1'b0, pc_q} + {1'b0, PC_ONE};
    assign br_pc    = br_full[ADDR_W-1:0];
    assign seq_pc   = seq_full[ADDR_W-1:0];
    assign br_ovf   = branch_taken & ~jump & (br_full[ADDR_W+1:ADDR_W] != 2'b00);
    assign seq_ovf  = seq_full[ADDR_W];
`else
    assign br_pc    = pc_q + branch_off;
    assign seq_pc   = pc_q + PC_ONE;
`endif

    assign target = jump ? jump_addr : br_pc;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        req_d        = req_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
`ifdef PC_WRAP_TRAP_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            ST_RST: begin
                state_d      = ST_FETCH;
                req_d        = 1'b1;
                fetch_pc_d   = RESET_PC;
                redir_pend_d = 1'b0;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    // A redirect coinciding with ack discards the word at once; no pending flag needed.
                    if (redirect) begin
                        fetch_pc_d   = target;
                        redir_pend_d = 1'b0;
                    end else if (redir_pend_q) begin
                        fetch_pc_d   = redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                        req_d   = 1'b0;
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        pc_d    = fetch_pc_q;
                    end
                end else if (redirect) begin
                    redir_pc_d   = target;
                    redir_pend_d = 1'b1;
                end
`ifdef PC_WRAP_TRAP_EN
                if (br_ovf) begin
                    state_d = ST_HALT;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d    = ST_FETCH;
                    req_d      = 1'b1;
                    valid_d    = 1'b0;
                    fetch_pc_d = target;
                end else if (!stall) begin
                    state_d    = ST_FETCH;
                    req_d      = 1'b1;
                    valid_d    = 1'b0;
                    fetch_pc_d = seq_pc;
                end
`ifdef PC_WRAP_TRAP_EN
                if (br_ovf || (!redirect && !stall && seq_ovf)) begin
                    state_d = ST_HALT;
                    req_d   = 1'b0;
                    valid_d = 1'b0;
                    fault_d = 1'b1;
                end
            end
            ST_HALT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
`endif
            end
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RST;
            fetch_pc_q   <= RESET_PC;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= RESET_PC;
`ifdef PC_WRAP_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
`ifdef PC_WRAP_TRAP_EN
            fault_q      <= fault_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
`ifdef PC_WRAP_TRAP_EN
    assign pc_fault    = fault_q;
`endif

endmodule
